// File: rtl/mac_operand_unpacker_if.sv
// Shared calculation/precision mode encodings and the operand unpacker bus:
// burst configuration, packed-word input stream and unpacked-element output stream.
package pkg;
  typedef enum logic [2:0] {
    MODE_IDLE = 3'd0,
    MODE_INT2 = 3'd1,
    MODE_INT4 = 3'd2,
    MODE_INT8 = 3'd3,
    MODE_BF16 = 3'd4,
    MODE_FP16 = 3'd5,
    MODE_TF32 = 3'd6,
    MODE_FP32 = 3'd7
  } mode_caculation;

  typedef enum logic {
    PREC_NORMAL = 1'b0,
    PREC_MIXED  = 1'b1
  } mode_precision;
endpackage

interface mac_operand_unpacker_if #(
  parameter int DATA_W  = 32,
  parameter int OUT_W   = 32,
  parameter int COUNT_W = 16
);
  logic                cfg_valid;
  logic                cfg_ready;
  pkg::mode_caculation cfg_mode;
  pkg::mode_precision  cfg_prec;
  logic [COUNT_W-1:0]  cfg_count;

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;

  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_data;
  logic                out_last;
  pkg::mode_caculation out_mode;
  pkg::mode_precision  out_prec;

  // The unpacker itself.
  modport slave (
    input  cfg_valid, cfg_mode, cfg_prec, cfg_count,
    input  in_valid, in_data, out_ready,
    output cfg_ready, in_ready,
    output out_valid, out_data, out_last, out_mode, out_prec
  );

  // The operand buffer / MAC array side driving and consuming the streams.
  modport master (
    output cfg_valid, cfg_mode, cfg_prec, cfg_count,
    output in_valid, in_data, out_ready,
    input  cfg_ready, in_ready,
    input  out_valid, out_data, out_last, out_mode, out_prec
  );
endinterface

// File: rtl/mac_operand_unpacker.sv
// Burst-oriented operand unpacker: splits packed words into one expanded MAC
// element per cycle according to the latched calculation mode.
module mac_operand_unpacker
  import pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OUT_W   = 32,
  parameter int COUNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mac_operand_unpacker_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_mode
);

  localparam int IDX_W = $clog2(DATA_W / 2);  // INT2 gives the most elements per word
  localparam int SH_W  = $clog2(DATA_W);

  if (OUT_W != 32) begin : g_out_w_check
    $error("mac_operand_unpacker: OUT_W must be 32");
  end
  if (DATA_W != 32 && DATA_W != 64) begin : g_data_w_check
    $error("mac_operand_unpacker: DATA_W must be 32 or 64");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

  state_t               state_q, state_d;
  mode_caculation       mode_q;
  mode_precision        prec_q;
  logic [COUNT_W-1:0]   words_left_q;
  logic [IDX_W-1:0]     elem_idx_q;
  logic [DATA_W-1:0]    data_q;
  logic                 done_q, err_q;

  logic [2:0]           elem_lg;
  logic [IDX_W-1:0]     last_idx;
  logic                 at_last;
  logic [SH_W-1:0]      shamt;
  logic [31:0]          raw;
  logic [31:0]          elem;
  logic                 word_take, emit_take;

  // Element geometry from the latched mode: log2 of element width and last index.
  always_comb begin
    unique case (mode_q)
      MODE_INT2:            elem_lg = 3'd1;
      MODE_INT4:            elem_lg = 3'd2;
      MODE_INT8:            elem_lg = 3'd3;
      MODE_BF16, MODE_FP16: elem_lg = 3'd4;
      default:              elem_lg = 3'd5;
    endcase
    last_idx = IDX_W'((DATA_W >> elem_lg) - 1);
    at_last  = (elem_idx_q == last_idx);
    shamt    = SH_W'(elem_idx_q) << elem_lg;
    raw      = 32'(data_q >> shamt);
  end

  always_comb begin
    unique case (mode_q)
      MODE_INT2:            elem = {{30{raw[1]}}, raw[1:0]};
      MODE_INT4:            elem = {{28{raw[3]}}, raw[3:0]};
      MODE_INT8:            elem = {{24{raw[7]}}, raw[7:0]};
      MODE_BF16, MODE_FP16: elem = {raw[15:0], 16'b0};
      MODE_TF32:            elem = {raw[31:13], 13'b0};
      MODE_FP32:            elem = raw;
      default:              elem = '0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    bus.cfg_ready = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.cfg_ready = 1'b1;
        if (bus.cfg_valid && bus.cfg_mode != MODE_IDLE && bus.cfg_count != '0)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_d = S_EMIT;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        // Refill in the same cycle as the last element leaves: no bubble between words.
        if (bus.out_ready && at_last) begin
          if (words_left_q != '0) begin
            bus.in_ready = 1'b1;
            if (!bus.in_valid) state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign word_take    = bus.in_valid && bus.in_ready;
  assign emit_take    = bus.out_valid && bus.out_ready;
  assign bus.out_data = elem;
  assign bus.out_last = (state_q == S_EMIT) && (words_left_q == '0) && at_last;
  assign bus.out_mode = mode_q;
  assign bus.out_prec = prec_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err_mode     = err_q;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= MODE_IDLE;
      prec_q       <= PREC_NORMAL;
      words_left_q <= '0;
      elem_idx_q   <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      err_q   <= 1'b0;

      if (state_q == S_IDLE && bus.cfg_valid) begin
        if (bus.cfg_mode == MODE_IDLE) begin
          err_q <= 1'b1;
        end else begin
          mode_q       <= bus.cfg_mode;
          prec_q       <= bus.cfg_prec;
          words_left_q <= bus.cfg_count;
          if (bus.cfg_count == '0) done_q <= 1'b1;
        end
      end

      // A word is only taken while words_left is non-zero, so it cannot underflow.
      if (word_take) begin
        data_q       <= bus.in_data;
        elem_idx_q   <= '0;
        words_left_q <= words_left_q - 1'b1;
      end else if (emit_take) begin
        elem_idx_q <= at_last ? '0 : elem_idx_q + 1'b1;
        if (bus.out_last) done_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_unpacker.sv
// Directed, table-driven bench for mac_operand_unpacker (DATA_W = 32):
// per-mode element vectors plus hand-written burst, stall and reset sequences.
module tb_mac_operand_unpacker;
  import pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, err_mode;

  mac_operand_unpacker_if #(.DATA_W(32), .OUT_W(32), .COUNT_W(16)) bus ();

  mac_operand_unpacker #(.DATA_W(32), .OUT_W(32), .COUNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err_mode (err_mode)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Burst driver results.
  logic [31:0] words    [4];
  logic [31:0] got      [64];
  logic        got_last [64];
  int          got_cyc  [64];
  int          n_got;
  int          done_cyc;
  bit          done_seen;

  // Config, feed words[] with in_valid held high, out_ready = 1; collect elements until done.
  task automatic run_burst(input mode_caculation m, input mode_precision p, input int count);
    int widx;
    for (int k = 0; k < 64; k++) begin
      got[k]      = 'x;
      got_last[k] = 1'bx;
      got_cyc[k]  = -1;
    end
    n_got     = 0;
    done_seen = 0;
    done_cyc  = -1;
    widx      = 0;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = m;
    bus.cfg_prec  = p;
    bus.cfg_count = 16'(count);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      bus.in_valid = (widx < count);
      bus.in_data  = (widx < count) ? words[widx] : 32'h0;
      #1;
      if (done) begin
        done_seen = 1;
        done_cyc  = c;
      end else begin
        if (bus.out_valid && bus.out_ready && n_got < 64) begin
          got[n_got]      = bus.out_data;
          got_last[n_got] = bus.out_last;
          got_cyc[n_got]  = c;
          n_got++;
        end
        if (bus.in_valid && bus.in_ready) widx++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done_seen) check("burst_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    mode_caculation mode;
    logic [31:0]    word;
    int             idx;
    logic [31:0]    exp;
  } vec_t;

  typedef struct {
    logic        rdy;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic        ol;
    logic        dn;
  } step_t;

  vec_t  vecs  [14];
  step_t steps [10];
  bit    any_done;

  initial begin
    // Single-word bursts: {mode, word, element index, expected expansion}.
    vecs[0]  = '{MODE_INT4, 32'h8F07A5E1, 0,  32'h00000001};
    vecs[1]  = '{MODE_INT4, 32'h8F07A5E1, 1,  32'hFFFFFFFE};
    vecs[2]  = '{MODE_INT4, 32'h8F07A5E1, 3,  32'hFFFFFFFA};
    vecs[3]  = '{MODE_INT4, 32'h8F07A5E1, 7,  32'hFFFFFFF8};
    vecs[4]  = '{MODE_INT2, 32'h8000001B, 0,  32'hFFFFFFFF};
    vecs[5]  = '{MODE_INT2, 32'h8000001B, 1,  32'hFFFFFFFE};
    vecs[6]  = '{MODE_INT2, 32'h8000001B, 2,  32'h00000001};
    vecs[7]  = '{MODE_INT2, 32'h8000001B, 15, 32'hFFFFFFFE};
    vecs[8]  = '{MODE_BF16, 32'h3C00C000, 0,  32'hC0000000};
    vecs[9]  = '{MODE_BF16, 32'h3C00C000, 1,  32'h3C000000};
    vecs[10] = '{MODE_TF32, 32'h3F801FFF, 0,  32'h3F800000};
    vecs[11] = '{MODE_TF32, 32'hFFFFFFFF, 0,  32'hFFFFE000};
    vecs[12] = '{MODE_FP32, 32'h3F801FFF, 0,  32'h3F801FFF};
    vecs[13] = '{MODE_FP16, 32'h00018000, 1,  32'h00010000};

    // FP16, two words 0x3C00C000, out_ready alternating 0/1 from the LOAD cycle.
    steps[0] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
    steps[1] = '{1'b0, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0};
    steps[2] = '{1'b1, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0};
    steps[3] = '{1'b0, 1'b1, 32'h3C000000, 1'b0, 1'b0, 1'b0};
    steps[4] = '{1'b1, 1'b1, 32'h3C000000, 1'b1, 1'b0, 1'b0};
    steps[5] = '{1'b0, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0};
    steps[6] = '{1'b1, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0};
    steps[7] = '{1'b0, 1'b1, 32'h3C000000, 1'b0, 1'b1, 1'b0};
    steps[8] = '{1'b1, 1'b1, 32'h3C000000, 1'b0, 1'b1, 1'b0};
    steps[9] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1};

    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_mode  = MODE_IDLE;
    bus.cfg_prec  = PREC_NORMAL;
    bus.cfg_count = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last",  32'(bus.out_last),  32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_done",      32'(done),          32'd0);
    check("rst_err_mode",  32'(err_mode),      32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rst_out_data",  bus.out_data,       32'd0);
    check("rst_out_mode",  32'(bus.out_mode),  32'd0);
    check("rst_out_prec",  32'(bus.out_prec),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // INT8 single word: sign extension, out_last on the 4th, done right after.
    words[0] = 32'h81807F01;
    run_burst(MODE_INT8, PREC_MIXED, 1);
    check("int8_n",     32'(n_got), 32'd4);
    check("int8_e0",    got[0], 32'h00000001);
    check("int8_e1",    got[1], 32'h0000007F);
    check("int8_e2",    got[2], 32'hFFFFFF80);
    check("int8_e3",    got[3], 32'hFFFFFF81);
    check("int8_last",  {28'd0, got_last[3], got_last[2], got_last[1], got_last[0]}, 32'h8);
    check("int8_span",  32'(got_cyc[3] - got_cyc[0]), 32'd3);
    check("int8_done",  32'(done_cyc), 32'(got_cyc[3] + 1));
    check("int8_mode",  32'(bus.out_mode), 32'(MODE_INT8));
    check("int8_prec",  32'(bus.out_prec), 32'd1);

    for (int i = 0; i < 14; i++) begin
      words[0] = vecs[i].word;
      run_burst(vecs[i].mode, PREC_NORMAL, 1);
      check($sformatf("vec%0d_%s_e%0d", i, vecs[i].mode.name(), vecs[i].idx),
            got[vecs[i].idx], vecs[i].exp);
    end

    // INT2 two-word burst, back to back with no bubble.
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'h55555555;
    run_burst(MODE_INT2, PREC_NORMAL, 2);
    check("int2_n",    32'(n_got), 32'd32);
    check("int2_span", 32'(got_cyc[31] - got_cyc[0]), 32'd31);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("int2_e%0d", k), got[k], (k < 16) ? 32'hFFFFFFFF : 32'h00000001);
      check($sformatf("int2_last%0d", k), 32'(got_last[k]), (k == 31) ? 32'd1 : 32'd0);
    end

    // Backpressure with FP16.
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = MODE_FP16;
    bus.cfg_prec  = PREC_NORMAL;
    bus.cfg_count = 16'd2;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h3C00C000;
    for (int s = 0; s < 10; s++) begin
      bus.out_ready = steps[s].rdy;
      #1;
      check($sformatf("bp%0d_out_valid", s), 32'(bus.out_valid), 32'(steps[s].ov));
      check($sformatf("bp%0d_in_ready", s),  32'(bus.in_ready),  32'(steps[s].ir));
      check($sformatf("bp%0d_out_last", s),  32'(bus.out_last),  32'(steps[s].ol));
      check($sformatf("bp%0d_done", s),      32'(done),          32'(steps[s].dn));
      if (steps[s].ov) check($sformatf("bp%0d_out_data", s), bus.out_data, steps[s].od);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // MODE_IDLE config is rejected.
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = MODE_IDLE;
    bus.cfg_count = 16'd3;
    #1;
    check("err_cfg_ready_pre", 32'(bus.cfg_ready), 32'd1);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1;
    check("err_pulse",     32'(err_mode),      32'd1);
    check("err_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("err_in_ready",  32'(bus.in_ready),  32'd0);
    check("err_busy",      32'(busy),          32'd0);
    @(negedge clk);
    #1;
    check("err_one_cycle", 32'(err_mode),      32'd0);
    check("err_in_ready2", 32'(bus.in_ready),  32'd0);

    // Zero-length burst: only a done pulse.
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = MODE_INT8;
    bus.cfg_count = 16'd0;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    #1;
    check("zero_done",      32'(done),          32'd1);
    check("zero_busy",      32'(busy),          32'd0);
    check("zero_in_ready",  32'(bus.in_ready),  32'd0);
    check("zero_out_valid", 32'(bus.out_valid), 32'd0);
    check("zero_err",       32'(err_mode),      32'd0);
    @(negedge clk);
    #1;
    check("zero_done_once", 32'(done),          32'd0);

    // Reset while element 2 of an INT8 word is on the output.
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_mode  = MODE_INT8;
    bus.cfg_count = 16'd1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h81807F01;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_e2", bus.out_data, 32'hFFFFFF80);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rstmid_busy",      32'(busy),          32'd0);
    check("rstmid_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    check("rstmid_done",      32'(done),          32'd0);
    rst = 1'b0;
    any_done = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) any_done = 1;
    end
    check("rstmid_no_done",     32'(any_done),      32'd0);
    check("rstmid_idle_valid",  32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_operand_unpacker.md
Name: mac_operand_unpacker

Overview:
Unpacks packed operand words into a stream of per-element lanes for the MAC datapath, one element per cycle, according to the calculation mode (INT2/INT4/INT8/BF16/FP16/TF32/FP32) and precision mode (normal/mixed) from the shared mode package. It generalises the mode definitions into a configurable, burst-oriented front end. It also adds working INT2 support, which was previously defined but unimplemented. It sits between the operand buffer/SRAM read port and the MAC array input register.

Parameters:
DATA_W, 32, packed input word width; multiple of 32 (32 or 64 supported).
OUT_W, 32, output element container width; fixed 32 in this generation, checked by elaboration assertion.
COUNT_W, 16, width of burst word count.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_valid  input  1  burst configuration valid
cfg_ready  output  1  unpacker can accept configuration (high only in IDLE)
cfg_mode  input  3  calculation mode, pkg::mode_caculation encoding
cfg_prec  input  1  pkg::mode_precision (0 normal, 1 mixed)
cfg_count  input  COUNT_W  number of input words in burst
in_valid  input  1  packed word valid
in_ready  output  1  packed word accepted when in_valid && in_ready
in_data  input  DATA_W  packed word, element 0 at LSBs
out_valid  output  1  element valid
out_ready  input  1  downstream accepts element
out_data  output  OUT_W  unpacked element
out_last  output  1  final element of burst
out_mode  output  3  latched burst mode, sideband
out_prec  output  1  latched precision, sideband
busy  output  1  high when not IDLE
done  output  1  one-cycle pulse when burst completes
err_mode  output  1  one-cycle pulse when config with MODE_IDLE is accepted

Behaviour:
- Reset values: out_valid, out_last, busy, done, err_mode, in_ready = 0; cfg_ready = 1 after reset; out_data, out_mode, out_prec = 0. The FSM enters IDLE, counters clear, and the holding register clears.
- Element width E by mode: INT2 = 2, INT4 = 4, INT8 = 8, BF16 = 16, FP16 = 16, TF32 = 32, FP32 = 32. Elements per word N = DATA_W/E.
- Element expansion into OUT_W:
  - INT modes: sign-extend (two's complement).
  - BF16/FP16: {elem, 16'b0}, left-aligned raw container.
  - TF32: {elem[31:13], 13'b0}, so the low 13 input bits are forced to zero.
  - FP32: passthrough.
- FSM IDLE:
  - cfg_ready = 1.
  - On cfg_valid with mode == MODE_IDLE: pulse err_mode, stay in IDLE.
  - On cfg_valid with cfg_count == 0: latch the config, pulse done next cycle, stay in IDLE.
  - Otherwise: latch mode, prec and count, then go to LOAD.
- FSM LOAD:
  - in_ready = 1.
  - On handshake, capture in_data, set elem_idx = 0, decrement words_left, go to EMIT.
  - out_valid rises the cycle after the handshake (latency 1).
- FSM EMIT:
  - out_valid = 1 and out_data = element elem_idx.
  - On out_ready, increment elem_idx.
  - in_ready = 1 only when elem_idx == N-1 && out_ready && words_left != 0, which gives back-to-back words at one element per cycle with no bubble.
  - After the last element of a word with no new word accepted: go to LOAD if words_left != 0, else go to IDLE.
- out_last = 1 when words_left == 0 && elem_idx == N-1.
- done pulses the cycle after the out_last handshake.
- Stall: while out_valid && !out_ready, out_data, out_last and the sideband outputs hold stable. elem_idx, words_left and the holding register do not change.
- Config is ignored outside IDLE (cfg_ready = 0). Mode changes only take effect at burst boundaries.
- Invalid pkg codes do not exist (3-bit enum fully decoded). MODE_IDLE is the only rejected value.
- Reset mid-burst: the burst is abandoned. Buffered data and partial output are dropped, and done is not pulsed.
- Counters: elem_idx wraps N-1 -> 0 on word change. words_left never underflows.

Test Plan:
- INT8, DATA_W=32, count=1, in_data=0x81807F01, out_ready=1 -> out_data 0x00000001, 0x0000007F, 0xFFFFFF80, 0xFFFFFF81 on 4 consecutive cycles; out_last on the 4th; done the next cycle.
- INT2, count=2, words 0xFFFFFFFF then 0x55555555, out_ready=1 -> 16x 0xFFFFFFFF then 16x 0x00000001 with no bubble; out_last on element 32 only.
- FP16/BF16 with backpressure: words 0x3C00C000, out_ready toggling 1010 -> outputs 0xC0000000 then 0x3C000000, each held stable while stalled; in_ready = 0 during stalls.
- TF32, in_data 0x3F801FFF -> out_data 0x3F800000; FP32 0x3F801FFF -> 0x3F801FFF.
- cfg_mode = MODE_IDLE -> err_mode pulse, cfg_ready stays 1, no in_ready.
- cfg_count = 0 -> only a done pulse.
- Reset asserted during EMIT at element 2 -> next cycle out_valid = 0, busy = 0, cfg_ready = 1, and no done.
